// File: rtl/lsu_stall_if.sv
// ============================================================================
// Module : lsu_stall_if
// Brief  : Core <-> load/store unit request/response bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lsu_stall_if;
    logic        i_req;
    logic        i_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic [31:0] o_ld_data;
    logic        o_done;
    logic        o_stall;
    logic        o_misalign;

    modport master (
        output i_req, i_wren, i_funct3, i_addr, i_st_data,
        input  o_ld_data, o_done, o_stall, o_misalign
    );

    modport slave (
        input  i_req, i_wren, i_funct3, i_addr, i_st_data,
        output o_ld_data, o_done, o_stall, o_misalign
    );
endinterface

`default_nettype wire

// File: rtl/lsu_stall.sv
// ============================================================================
// Module : lsu_stall
// Brief  : Multi-cycle byte/half/word load/store unit with wait-state DMEM
//          and memory-mapped LED / 7-seg / LCD / switch IO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_stall #(
    parameter int DMEM_AW = 11,
    parameter int MEM_LAT = 2,
    parameter int LEDR_W  = 17,
    parameter int LEDG_W  = 8
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    lsu_stall_if.slave       bus,
    input  wire logic [31:0] i_io_sw,
    output logic      [31:0] o_io_ledr,
    output logic      [31:0] o_io_ledg,
    output logic      [6:0]  o_io_hex0,
    output logic      [6:0]  o_io_hex1,
    output logic      [6:0]  o_io_hex2,
    output logic      [6:0]  o_io_hex3,
    output logic      [6:0]  o_io_hex4,
    output logic      [6:0]  o_io_hex5,
    output logic      [6:0]  o_io_hex6,
    output logic      [6:0]  o_io_hex7,
    output logic      [31:0] o_io_lcd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int          DMEM_WORDS = 1 << DMEM_AW;
    localparam logic [3:0]  CNT_INIT   = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;
    localparam bit          MEM_DIRECT = (MEM_LAT == 0);
    localparam logic [31:0] LEDR_MASK  = 32'((64'd1 << LEDR_W) - 64'd1);
    localparam logic [31:0] LEDG_MASK  = 32'((64'd1 << LEDG_W) - 64'd1);
    localparam logic [31:0] ADDR_LEDR  = 32'h1000_0000;
    localparam logic [31:0] ADDR_LEDG  = 32'h1000_1000;
    localparam logic [31:0] ADDR_HEXLO = 32'h1000_2000;
    localparam logic [31:0] ADDR_HEXHI = 32'h1000_3000;
    localparam logic [31:0] ADDR_LCD   = 32'h1000_4000;
    localparam logic [31:0] ADDR_SW    = 32'h1001_0000;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wren_q, wren_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] st_data_q, st_data_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [6:0]  hex_q [8];
    logic [6:0]  hex_d [8];
    logic [31:0] lcd_q, lcd_d;
    logic [31:0] sw_meta_q, sw_sync_q;

    logic [31:0] mem [DMEM_WORDS];

    // In IDLE the request is still on the inputs; afterwards it is the latched copy.
    logic        cur_idle, cur_wren;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_st;
    logic        is_b, is_h, is_uns, misalign;
    logic        sel_dmem, sel_ledr, sel_ledg, sel_hexlo, sel_hexhi, sel_lcd, sel_sw;
    logic [3:0]  be;
    logic [31:0] wdata, rdata, ld_fmt;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        commit, write_ok, mem_we;
    logic [DMEM_AW-1:0] mem_idx;

    assign cur_idle = (state_q == S_IDLE);
    assign cur_wren = cur_idle ? bus.i_wren    : wren_q;
    assign cur_f3   = cur_idle ? bus.i_funct3  : funct3_q;
    assign cur_addr = cur_idle ? bus.i_addr    : addr_q;
    assign cur_st   = cur_idle ? bus.i_st_data : st_data_q;

    // Stores only know SB/SH; every other store encoding is a full word.
    assign is_b   = cur_wren ? (cur_f3 == 3'b000) : (cur_f3[1:0] == 2'b00);
    assign is_h   = cur_wren ? (cur_f3 == 3'b001) : (cur_f3[1:0] == 2'b01);
    assign is_uns = !cur_wren && cur_f3[2] && (is_b || is_h);
    assign misalign = (is_h && cur_addr[0]) || (!is_b && !is_h && (cur_addr[1:0] != 2'b00));

    assign sel_dmem  = (cur_addr[31:DMEM_AW+2] == '0);
    assign sel_ledr  = (cur_addr[31:2] == ADDR_LEDR[31:2]);
    assign sel_ledg  = (cur_addr[31:2] == ADDR_LEDG[31:2]);
    assign sel_hexlo = (cur_addr[31:2] == ADDR_HEXLO[31:2]);
    assign sel_hexhi = (cur_addr[31:2] == ADDR_HEXHI[31:2]);
    assign sel_lcd   = (cur_addr[31:2] == ADDR_LCD[31:2]);
    assign sel_sw    = (cur_addr[31:2] == ADDR_SW[31:2]);
    assign mem_idx   = cur_addr[DMEM_AW+1:2];

    always_comb begin
        be    = 4'b1111;
        wdata = cur_st;
        if (is_b) begin
            be    = 4'b0001 << cur_addr[1:0];
            wdata = {4{cur_st[7:0]}};
        end else if (is_h) begin
            be    = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{cur_st[15:0]}};
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel_dmem)       rdata = mem[mem_idx];
        else if (sel_ledr)  rdata = ledr_q;
        else if (sel_ledg)  rdata = ledg_q;
        else if (sel_hexlo) rdata = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
        else if (sel_hexhi) rdata = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
        else if (sel_lcd)   rdata = lcd_q;
        else if (sel_sw)    rdata = sw_sync_q;
    end

    assign byte_v = rdata[{cur_addr[1:0], 3'b000} +: 8];
    assign half_v = cur_addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_fmt = rdata;
        if (is_b)      ld_fmt = is_uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        else if (is_h) ld_fmt = is_uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
    end

    // The access happens exactly on the edge that moves the FSM into RESP.
    assign commit   = (cur_idle && bus.i_req && (misalign || !sel_dmem || MEM_DIRECT))
                    || ((state_q == S_WAIT) && (cnt_q == 4'd0));
    assign write_ok = commit && cur_wren && !misalign;
    assign mem_we   = write_ok && sel_dmem && i_reset;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (en[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wren_d     = wren_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        st_data_d  = st_data_q;
        done_d     = 1'b0;
        misalign_d = misalign_q;
        ld_data_d  = ld_data_q;
        ledr_d     = ledr_q;
        ledg_d     = ledg_q;
        hex_d      = hex_q;
        lcd_d      = lcd_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    wren_d    = bus.i_wren;
                    funct3_d  = bus.i_funct3;
                    addr_d    = bus.i_addr;
                    st_data_d = bus.i_st_data;
                    if (misalign || !sel_dmem || MEM_DIRECT) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            done_d     = 1'b1;
            misalign_d = misalign;
            if (misalign)       ld_data_d = 32'd0;
            else if (!cur_wren) ld_data_d = ld_fmt;
        end

        if (write_ok) begin
            if (sel_ledr) ledr_d = merge(ledr_q, wdata, be) & LEDR_MASK;
            if (sel_ledg) ledg_d = merge(ledg_q, wdata, be) & LEDG_MASK;
            if (sel_lcd)  lcd_d  = merge(lcd_q, wdata, be);
            for (int i = 0; i < 4; i++) begin
                if (sel_hexlo && be[i]) hex_d[i]   = wdata[8*i +: 7];
                if (sel_hexhi && be[i]) hex_d[i+4] = wdata[8*i +: 7];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            wren_q     <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            st_data_q  <= 32'd0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            ld_data_q  <= 32'd0;
            ledr_q     <= 32'd0;
            ledg_q     <= 32'd0;
            for (int i = 0; i < 8; i++) hex_q[i] <= 7'd0;
            lcd_q      <= 32'd0;
            sw_meta_q  <= 32'd0;
            sw_sync_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wren_q     <= wren_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            st_data_q  <= st_data_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            ld_data_q  <= ld_data_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hex_q      <= hex_d;
            lcd_q      <= lcd_d;
            sw_meta_q  <= i_io_sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // DMEM has no reset; the write is gated by reset so an aborted store never lands.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign bus.o_stall    = (cur_idle && bus.i_req) || (state_q == S_WAIT);
    assign bus.o_done     = done_q;
    assign bus.o_misalign = misalign_q;
    assign bus.o_ld_data  = ld_data_q;

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];

endmodule

`default_nettype wire

// File: tb/tb_lsu_stall.sv
// ============================================================================
// Module : tb_lsu_stall
// Brief  : Directed and randomized check of lsu_stall against a byte-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_stall;
    localparam int DMEM_AW = 11;
    localparam int MEM_LAT = 2;
    localparam int LEDR_W  = 17;
    localparam int LEDG_W  = 8;
    localparam int DMEM_BYTES = 4 << DMEM_AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sw = 32'd0;
    logic [31:0] ledr, ledg, lcd;
    logic [6:0]  hx0, hx1, hx2, hx3, hx4, hx5, hx6, hx7;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    lsu_stall_if bus ();

    lsu_stall #(.DMEM_AW(DMEM_AW), .MEM_LAT(MEM_LAT), .LEDR_W(LEDR_W), .LEDG_W(LEDG_W)) dut (
        .i_clk(clk), .i_reset(rst_n), .bus(bus.slave), .i_io_sw(sw),
        .o_io_ledr(ledr), .o_io_ledg(ledg),
        .o_io_hex0(hx0), .o_io_hex1(hx1), .o_io_hex2(hx2), .o_io_hex3(hx3),
        .o_io_hex4(hx4), .o_io_hex5(hx5), .o_io_hex6(hx6), .o_io_hex7(hx7),
        .o_io_lcd(lcd)
    );

    // Reference model state: memory as a flat byte array, IO as plain values.
    logic [7:0]  m_mem [DMEM_BYTES];
    logic [31:0] m_ledr, m_ledg, m_lcd;
    logic [6:0]  m_hex [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input bit wr, input logic [2:0] f3);
        if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] wa);
        if (wa < DMEM_BYTES)
            return {m_mem[wa+3], m_mem[wa+2], m_mem[wa+1], m_mem[wa]};
        case (wa)
            32'h1000_0000: return m_ledr;
            32'h1000_1000: return m_ledg;
            32'h1000_2000: return {1'b0, m_hex[3], 1'b0, m_hex[2], 1'b0, m_hex[1], 1'b0, m_hex[0]};
            32'h1000_3000: return {1'b0, m_hex[7], 1'b0, m_hex[6], 1'b0, m_hex[5], 1'b0, m_hex[4]};
            32'h1000_4000: return m_lcd;
            32'h1001_0000: return sw;
            default:       return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        int n;
        bit uns;
        n   = acc_size(1'b0, f3);
        uns = (f3 == 3'd4) || (f3 == 3'd5);
        w   = word_at({a[31:2], 2'b00}) >> (8 * a[1:0]);
        if (n == 1) return uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
        if (n == 2) return uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        return w;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ba, wa;
        logic [7:0]  v;
        int lane;
        for (int i = 0; i < acc_size(1'b1, f3); i++) begin
            ba   = a + i;
            v    = d[8*i +: 8];
            wa   = {ba[31:2], 2'b00};
            lane = int'(ba[1:0]);
            if (ba < DMEM_BYTES) m_mem[ba] = v;
            else case (wa)
                32'h1000_0000: m_ledr[8*lane +: 8] = v;
                32'h1000_1000: m_ledg[8*lane +: 8] = v;
                32'h1000_2000: m_hex[lane]   = v[6:0];
                32'h1000_3000: m_hex[lane+4] = v[6:0];
                32'h1000_4000: m_lcd[8*lane +: 8] = v;
                default: ;
            endcase
        end
        m_ledr &= (32'd1 << LEDR_W) - 32'd1;
        m_ledg &= (32'd1 << LEDG_W) - 32'd1;
    endtask

    task automatic model_io_reset();
        m_ledr = 0; m_ledg = 0; m_lcd = 0;
        for (int i = 0; i < 8; i++) m_hex[i] = 7'd0;
    endtask

    task automatic check_io(input string tag);
        check({tag, " ledr"}, ledr, m_ledr);
        check({tag, " ledg"}, ledg, m_ledg);
        check({tag, " lcd"},  lcd,  m_lcd);
        check({tag, " hex0"}, {25'd0, hx0}, {25'd0, m_hex[0]});
        check({tag, " hex1"}, {25'd0, hx1}, {25'd0, m_hex[1]});
        check({tag, " hex2"}, {25'd0, hx2}, {25'd0, m_hex[2]});
        check({tag, " hex3"}, {25'd0, hx3}, {25'd0, m_hex[3]});
        check({tag, " hex4"}, {25'd0, hx4}, {25'd0, m_hex[4]});
        check({tag, " hex5"}, {25'd0, hx5}, {25'd0, m_hex[5]});
        check({tag, " hex6"}, {25'd0, hx6}, {25'd0, m_hex[6]});
        check({tag, " hex7"}, {25'd0, hx7}, {25'd0, m_hex[7]});
    endtask

    // One complete access; expected stalls, misalign and data come from the model.
    task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int n, stalls, cyc, exp_stalls;
        bit mis;
        logic [31:0] exp_ld;
        n   = acc_size(wr, f3);
        mis = ((n == 2) && (a % 2 != 0)) || ((n == 4) && (a % 4 != 0));
        exp_stalls = mis ? 1 : ((a < DMEM_BYTES) ? 1 + MEM_LAT : 1);
        exp_ld = model_load(f3, a);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = wr; bus.i_funct3 = f3;
        bus.i_addr = a;   bus.i_st_data = d;
        #1;
        stalls = 0;
        cyc = 0;
        while (bus.o_done !== 1'b1 && cyc < 40) begin
            if (bus.o_stall === 1'b1) stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " done"}, {31'd0, bus.o_done}, 32'd1);
        check({tag, " stall_in_resp"}, {31'd0, bus.o_stall}, 32'd0);
        check({tag, " stall_cycles"}, stalls, exp_stalls);
        check({tag, " misalign"}, {31'd0, bus.o_misalign}, {31'd0, mis});
        if (!wr && !mis) check({tag, " ld_data"}, bus.o_ld_data, exp_ld);
        if (wr && !mis) begin
            model_store(f3, a, d);
            check_io(tag);
        end
        @(negedge clk);
        bus.i_req = 1'b0;
    endtask

    logic [31:0] ra, rd;
    int cat;

    initial begin
        logic [31:0] io_words [6];
        io_words[0] = 32'h1000_0000; io_words[1] = 32'h1000_1000; io_words[2] = 32'h1000_2000;
        io_words[3] = 32'h1000_3000; io_words[4] = 32'h1000_4000; io_words[5] = 32'h1001_0000;
        bus.i_req = 0; bus.i_wren = 0; bus.i_funct3 = 0; bus.i_addr = 0; bus.i_st_data = 0;
        model_io_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst done",     {31'd0, bus.o_done}, 32'd0);
        check("rst stall",    {31'd0, bus.o_stall}, 32'd0);
        check("rst misalign", {31'd0, bus.o_misalign}, 32'd0);
        check("rst ld_data",  bus.o_ld_data, 32'd0);
        check_io("rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < 64; w++) access(1'b1, 3'd2, w * 4, $urandom, "init_lo");
        for (int w = 0; w < 4; w++)  access(1'b1, 3'd2, 32'h1FF0 + w * 4, $urandom, "init_hi");
        access(1'b1, 3'd2, 32'h200, 32'hCAFE_F00D, "init_200");

        // T1: word store/load round trip with wait states
        access(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, "t1_sw");
        access(1'b0, 3'd2, 32'h100, 0, "t1_lw");
        check("t1 lw const", bus.o_ld_data, 32'hDEAD_BEEF);

        // T2: byte store and sub-word loads
        access(1'b1, 3'd0, 32'h101, 32'h0000_0080, "t2_sb");
        access(1'b0, 3'd0, 32'h101, 0, "t2_lb");
        check("t2 lb const", bus.o_ld_data, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h101, 0, "t2_lbu");
        check("t2 lbu const", bus.o_ld_data, 32'h0000_0080);
        access(1'b0, 3'd2, 32'h100, 0, "t2_lw");
        check("t2 lw const", bus.o_ld_data, 32'hDEAD_80EF);
        access(1'b0, 3'd5, 32'h102, 0, "t2_lhu");
        check("t2 lhu const", bus.o_ld_data, 32'h0000_DEAD);

        // T3: misaligned accesses complete without touching memory
        access(1'b0, 3'd1, 32'h103, 0, "t3_lh_mis");
        access(1'b1, 3'd2, 32'h102, 32'h1234_5678, "t3_sw_mis");
        access(1'b0, 3'd2, 32'h100, 0, "t3_lw");
        check("t3 lw const", bus.o_ld_data, 32'hDEAD_80EF);

        // T4: IO registers and synchronised switches
        access(1'b1, 3'd2, 32'h1000_0000, 32'hFFFF_FFFF, "t4_ledr");
        check("t4 ledr const", ledr, 32'h0001_FFFF);
        access(1'b1, 3'd2, 32'h1000_2000, 32'h4079_7924, "t4_hex");
        check("t4 hex0 const", {25'd0, hx0}, 32'h24);
        check("t4 hex3 const", {25'd0, hx3}, 32'h40);
        @(negedge clk);
        sw = 32'h0001_2345;
        repeat (2) @(negedge clk);
        access(1'b0, 3'd2, 32'h1001_0000, 0, "t4_sw");
        check("t4 sw const", bus.o_ld_data, 32'h0001_2345);

        // T6: unmapped space, including just past the top of DMEM
        access(1'b0, 3'd2, 32'h2000_0000, 0, "t6_lw_unmapped");
        check("t6 lw const", bus.o_ld_data, 32'd0);
        access(1'b1, 3'd2, 32'h2000_0000, 32'hFFFF_FFFF, "t6_sw_unmapped");
        access(1'b0, 3'd2, 32'h2000, 0, "t6_lw_past_dmem");
        access(1'b0, 3'd2, 32'h1FFC, 0, "t6_lw_top_dmem");

        // T5: reset during WAIT abandons the store
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = 1'b1; bus.i_funct3 = 3'd2;
        bus.i_addr = 32'h200; bus.i_st_data = 32'h1111_1111;
        @(posedge clk); #1;
        check("t5 stall in wait", {31'd0, bus.o_stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_req = 1'b0;
        #1;
        model_io_reset();
        check("t5 stall after rst", {31'd0, bus.o_stall}, 32'd0);
        check("t5 done after rst",  {31'd0, bus.o_done}, 32'd0);
        check_io("t5 rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        access(1'b0, 3'd2, 32'h200, 0, "t5_lw");
        check("t5 lw const", bus.o_ld_data, 32'hCAFE_F00D);

        // Randomized traffic over DMEM, IO and unmapped space
        for (int it = 0; it < 300; it++) begin
            if (it % 50 == 0) begin
                @(negedge clk);
                sw = $urandom;
                repeat (3) @(negedge clk);
            end
            cat = $urandom_range(0, 9);
            case (cat)
                0, 1, 2, 3: ra = $urandom_range(0, 255);
                4:          ra = 32'h1FF0 + $urandom_range(0, 15);
                5:          ra = 32'h2000 + $urandom_range(0, 15);
                6, 7, 8:    ra = io_words[$urandom_range(0, 5)] + $urandom_range(0, 3);
                default:    ra = 32'h1000_0004 + $urandom_range(0, 3);
            endcase
            rd = $urandom;
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rd, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
